// File: rtl/control_sequencer.sv
// control_sequencer
// Microcode control unit for the 8-bit CPU. It steps through fixed T-states
// and decodes the IR opcode nibble into the one-cycle load selects, the bus
// drive enables, the ALU mode, the RAM write strobe and the PC controls.
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   rst_n    in   synchronous active-low reset (state -> RST)
//   enable   in   run/stall; 0 holds state and forces all controls to 0
//   opcode   in   IR[7:4]
//   pc_out, pc_inc, pc_load            out  PC bus drive / increment / load
//   mar_sel                            out  MAR load select
//   ram_out, ram_we                    out  RAM bus drive / write
//   ir_sel, ir_out                     out  IR load select / operand bus drive
//   a_sel, a_out, b_sel, out_sel       out  register load selects, A bus drive
//   alu_out, alu_sub                   out  ALU bus drive / subtract mode
//   halted                             out  high in HALT
//   tstate                             out  T0..T4 = 0..4, HALT = 5, RST = 7
module control_sequencer #(
    parameter int OPCODE_W      = 4,
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_sel,
    output logic                ram_out,
    output logic                ram_we,
    output logic                ir_sel,
    output logic                ir_out,
    output logic                a_sel,
    output logic                a_out,
    output logic                b_sel,
    output logic                out_sel,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                halted,
    output logic [2:0]          tstate
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5,
        ST_RST  = 3'd7
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_sel;
        logic ram_out;
        logic ram_we;
        logic ir_sel;
        logic ir_out;
        logic a_sel;
        logic a_out;
        logic b_sel;
        logic out_sel;
        logic alu_out;
        logic alu_sub;
    } ctl_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

    state_t state_r;
    state_t state_next_s;
    ctl_t   ctl_s;
    ctl_t   ctl_g_s;

    logic op_lda_s, op_add_s, op_sub_s, op_sta_s, op_ldi_s, op_jmp_s, op_out_s;
    logic op_undef_s, op_hlt_s, op_nop_s, op_mem_s, op_alu_s;

    assign op_lda_s   = (opcode == OP_LDA);
    assign op_add_s   = (opcode == OP_ADD);
    assign op_sub_s   = (opcode == OP_SUB);
    assign op_sta_s   = (opcode == OP_STA);
    assign op_ldi_s   = (opcode == OP_LDI);
    assign op_jmp_s   = (opcode == OP_JMP);
    assign op_out_s   = (opcode == OP_OUT);
    assign op_undef_s = !(op_lda_s || op_add_s || op_sub_s || op_sta_s || op_ldi_s ||
                          op_jmp_s || op_out_s || (opcode == OP_NOP) || (opcode == OP_HLT));
    // Undefined opcodes fold into either HLT or NOP depending on the build option.
    assign op_hlt_s   = (opcode == OP_HLT) || (op_undef_s && HALT_ON_UNDEF);
    assign op_nop_s   = (opcode == OP_NOP) || (op_undef_s && !HALT_ON_UNDEF);
    // Opcodes that address memory through the MAR and therefore need T3.
    assign op_mem_s   = op_lda_s || op_add_s || op_sub_s || op_sta_s;
    assign op_alu_s   = op_add_s || op_sub_s;

    // State register: reset wins over stall, stall holds the current step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RST;
        end else if (enable) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state and raw control decode from the current step and opcode.
    always_comb begin
        state_next_s = state_r;
        ctl_s        = '0;
        case (state_r)
            ST_RST: begin
                state_next_s = ST_T0;
            end
            ST_T0: begin
                ctl_s.pc_out  = 1'b1;
                ctl_s.mar_sel = 1'b1;
                state_next_s  = ST_T1;
            end
            ST_T1: begin
                ctl_s.ram_out = 1'b1;
                ctl_s.ir_sel  = 1'b1;
                ctl_s.pc_inc  = 1'b1;
                if (op_nop_s) begin
                    state_next_s = ST_T0;
                end else begin
                    state_next_s = ST_T2;
                end
            end
            ST_T2: begin
                if (op_mem_s) begin
                    ctl_s.ir_out  = 1'b1;
                    ctl_s.mar_sel = 1'b1;
                    state_next_s  = ST_T3;
                end else if (op_ldi_s) begin
                    ctl_s.ir_out = 1'b1;
                    ctl_s.a_sel  = 1'b1;
                    state_next_s = ST_T0;
                end else if (op_jmp_s) begin
                    ctl_s.ir_out  = 1'b1;
                    ctl_s.pc_load = 1'b1;
                    state_next_s  = ST_T0;
                end else if (op_out_s) begin
                    ctl_s.a_out   = 1'b1;
                    ctl_s.out_sel = 1'b1;
                    state_next_s  = ST_T0;
                end else if (op_hlt_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_T3: begin
                if (op_lda_s) begin
                    ctl_s.ram_out = 1'b1;
                    ctl_s.a_sel   = 1'b1;
                    state_next_s  = ST_T0;
                end else if (op_alu_s) begin
                    ctl_s.ram_out = 1'b1;
                    ctl_s.b_sel   = 1'b1;
                    state_next_s  = ST_T4;
                end else if (op_sta_s) begin
                    ctl_s.a_out  = 1'b1;
                    ctl_s.ram_we = 1'b1;
                    state_next_s = ST_T0;
                end else begin
                    state_next_s = ST_T0;
                end
            end
            ST_T4: begin
                if (op_alu_s) begin
                    ctl_s.alu_out = 1'b1;
                    ctl_s.a_sel   = 1'b1;
                    ctl_s.alu_sub = op_sub_s;
                end else begin
                    ctl_s.alu_out = 1'b0;
                end
                state_next_s = ST_T0;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                // The unused encoding 6 recovers through RST.
                state_next_s = ST_RST;
            end
        endcase
    end

    // A stalled sequencer must not pulse any register select or bus driver.
    assign ctl_g_s = enable ? ctl_s : '0;

    assign pc_out  = ctl_g_s.pc_out;
    assign pc_inc  = ctl_g_s.pc_inc;
    assign pc_load = ctl_g_s.pc_load;
    assign mar_sel = ctl_g_s.mar_sel;
    assign ram_out = ctl_g_s.ram_out;
    assign ram_we  = ctl_g_s.ram_we;
    assign ir_sel  = ctl_g_s.ir_sel;
    assign ir_out  = ctl_g_s.ir_out;
    assign a_sel   = ctl_g_s.a_sel;
    assign a_out   = ctl_g_s.a_out;
    assign b_sel   = ctl_g_s.b_sel;
    assign out_sel = ctl_g_s.out_sel;
    assign alu_out = ctl_g_s.alu_out;
    assign alu_sub = ctl_g_s.alu_sub;
    assign halted  = (state_r == ST_HALT);
    assign tstate  = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a directed vector table on the
// HALT_ON_UNDEF=0 build, hand-written multi-cycle sequences, then a random
// sweep of both builds against an instruction-step reference model.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable;
    logic [3:0] opcode;

    logic [1:0] pc_out_o, pc_inc_o, pc_load_o, mar_sel_o, ram_out_o, ram_we_o, ir_sel_o;
    logic [1:0] ir_out_o, a_sel_o, a_out_o, b_sel_o, out_sel_o, alu_out_o, alu_sub_o, halted_o;
    logic [2:0] ts_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_sequencer #(.OPCODE_W(4), .HALT_ON_UNDEF(g == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .opcode(opcode),
            .pc_out(pc_out_o[g]), .pc_inc(pc_inc_o[g]), .pc_load(pc_load_o[g]),
            .mar_sel(mar_sel_o[g]), .ram_out(ram_out_o[g]), .ram_we(ram_we_o[g]),
            .ir_sel(ir_sel_o[g]), .ir_out(ir_out_o[g]), .a_sel(a_sel_o[g]),
            .a_out(a_out_o[g]), .b_sel(b_sel_o[g]), .out_sel(out_sel_o[g]),
            .alu_out(alu_out_o[g]), .alu_sub(alu_sub_o[g]), .halted(halted_o[g]),
            .tstate(ts_o[g])
        );
    end

    localparam logic [13:0] C_PC_OUT  = 14'h2000, C_PC_INC  = 14'h1000, C_PC_LOAD = 14'h0800;
    localparam logic [13:0] C_MAR     = 14'h0400, C_RAM_OUT = 14'h0200, C_RAM_WE  = 14'h0100;
    localparam logic [13:0] C_IR_SEL  = 14'h0080, C_IR_OUT  = 14'h0040, C_A_SEL   = 14'h0020;
    localparam logic [13:0] C_A_OUT   = 14'h0010, C_B_SEL   = 14'h0008, C_OUT_SEL = 14'h0004;
    localparam logic [13:0] C_ALU_OUT = 14'h0002, C_ALU_SUB = 14'h0001;
    localparam logic [13:0] F0 = C_PC_OUT | C_MAR;
    localparam logic [13:0] F1 = C_RAM_OUT | C_IR_SEL | C_PC_INC;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [13:0] ctl_of(int d);
        return {pc_out_o[d], pc_inc_o[d], pc_load_o[d], mar_sel_o[d], ram_out_o[d],
                ram_we_o[d], ir_sel_o[d], ir_out_o[d], a_sel_o[d], a_out_o[d],
                b_sel_o[d], out_sel_o[d], alu_out_o[d], alu_sub_o[d]};
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_true(string nm, bit cond, int act);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: invariant broken, value %0h", nm, act);
        end
    endtask

    task automatic chk_dut(string nm, int d, int ts, logic [13:0] ctl, bit h);
        chk({nm, "_tstate"}, int'(ts_o[d]), ts);
        chk({nm, "_ctl"}, int'(ctl_of(d)), int'(ctl));
        chk({nm, "_halted"}, int'(halted_o[d]), int'(h));
    endtask

    // One clock cycle: inputs set on the falling edge, outputs sampled 1ns later.
    task automatic drive(bit rn, bit en, logic [3:0] op);
        @(negedge clk);
        rst_n  = rn;
        enable = en;
        opcode = op;
        #1;
    endtask

    // Reference model: per build, each opcode is a list of control sets, one
    // per enabled cycle, starting with the two fetch steps.
    int          len_t [2][16];
    logic [13:0] stp_t [2][16][5];
    bit          hlt_t [2][16];

    task automatic fill_model();
        for (int p = 0; p < 2; p++) begin
            for (int o = 0; o < 16; o++) begin
                for (int k = 0; k < 5; k++) stp_t[p][o][k] = 14'h0;
                stp_t[p][o][0] = F0;
                stp_t[p][o][1] = F1;
                hlt_t[p][o] = 1'b0;
                case (o)
                    0: len_t[p][o] = 2;
                    1: begin len_t[p][o] = 4; stp_t[p][o][2] = C_IR_OUT | C_MAR;
                             stp_t[p][o][3] = C_RAM_OUT | C_A_SEL; end
                    2, 3: begin len_t[p][o] = 5; stp_t[p][o][2] = C_IR_OUT | C_MAR;
                             stp_t[p][o][3] = C_RAM_OUT | C_B_SEL;
                             stp_t[p][o][4] = C_ALU_OUT | C_A_SEL | ((o == 3) ? C_ALU_SUB : 14'h0); end
                    4: begin len_t[p][o] = 4; stp_t[p][o][2] = C_IR_OUT | C_MAR;
                             stp_t[p][o][3] = C_A_OUT | C_RAM_WE; end
                    5: begin len_t[p][o] = 3; stp_t[p][o][2] = C_IR_OUT | C_A_SEL; end
                    6: begin len_t[p][o] = 3; stp_t[p][o][2] = C_IR_OUT | C_PC_LOAD; end
                    14: begin len_t[p][o] = 3; stp_t[p][o][2] = C_A_OUT | C_OUT_SEL; end
                    15: begin len_t[p][o] = 3; hlt_t[p][o] = 1'b1; end
                    default: begin
                        len_t[p][o] = (p == 1) ? 3 : 2;
                        hlt_t[p][o] = (p == 1);
                    end
                endcase
            end
        end
    endtask

    typedef struct {
        bit          chk;
        bit          rn;
        bit          en;
        logic [3:0]  op;
        logic [2:0]  ts;
        logic [13:0] ctl;
    } vec_t;
    vec_t vt[$];

    task automatic add(bit c, bit rn, bit en, logic [3:0] op, logic [2:0] ts, logic [13:0] ctl);
        vec_t e;
        e.chk = c; e.rn = rn; e.en = en; e.op = op; e.ts = ts; e.ctl = ctl;
        vt.push_back(e);
    endtask

    int ms [2];

    initial begin
        rst_n = 1'b0; enable = 1'b0; opcode = 4'h0;
        fill_model();

        // Reset then LDI fetch/execute
        add(0, 0, 1, 4'h5, 3'd7, 14'h0);
        add(1, 0, 1, 4'h5, 3'd7, 14'h0);
        add(1, 1, 1, 4'h5, 3'd7, 14'h0);
        add(1, 1, 1, 4'h5, 3'd0, F0);
        add(1, 1, 1, 4'h5, 3'd1, F1);
        add(1, 1, 1, 4'h5, 3'd2, C_IR_OUT | C_A_SEL);
        // ADD
        add(1, 1, 1, 4'h2, 3'd0, F0);
        add(1, 1, 1, 4'h2, 3'd1, F1);
        add(1, 1, 1, 4'h2, 3'd2, C_IR_OUT | C_MAR);
        add(1, 1, 1, 4'h2, 3'd3, C_RAM_OUT | C_B_SEL);
        add(1, 1, 1, 4'h2, 3'd4, C_ALU_OUT | C_A_SEL);
        // SUB
        add(1, 1, 1, 4'h3, 3'd0, F0);
        add(1, 1, 1, 4'h3, 3'd1, F1);
        add(1, 1, 1, 4'h3, 3'd2, C_IR_OUT | C_MAR);
        add(1, 1, 1, 4'h3, 3'd3, C_RAM_OUT | C_B_SEL);
        add(1, 1, 1, 4'h3, 3'd4, C_ALU_OUT | C_A_SEL | C_ALU_SUB);
        // LDA with a 3-cycle stall in T3
        add(1, 1, 1, 4'h1, 3'd0, F0);
        add(1, 1, 1, 4'h1, 3'd1, F1);
        add(1, 1, 1, 4'h1, 3'd2, C_IR_OUT | C_MAR);
        add(1, 1, 0, 4'h1, 3'd3, 14'h0);
        add(1, 1, 0, 4'h1, 3'd3, 14'h0);
        add(1, 1, 0, 4'h1, 3'd3, 14'h0);
        add(1, 1, 1, 4'h1, 3'd3, C_RAM_OUT | C_A_SEL);
        // Undefined 0x9 and NOP 0x0: two-cycle instructions
        add(1, 1, 1, 4'h9, 3'd0, F0);
        add(1, 1, 1, 4'h9, 3'd1, F1);
        add(1, 1, 1, 4'h9, 3'd0, F0);
        add(1, 1, 1, 4'h0, 3'd1, F1);
        add(1, 1, 1, 4'h0, 3'd0, F0);
        add(1, 1, 1, 4'h0, 3'd1, F1);
        // STA, JMP, OUT
        add(1, 1, 1, 4'h4, 3'd0, F0);
        add(1, 1, 1, 4'h4, 3'd1, F1);
        add(1, 1, 1, 4'h4, 3'd2, C_IR_OUT | C_MAR);
        add(1, 1, 1, 4'h4, 3'd3, C_A_OUT | C_RAM_WE);
        add(1, 1, 1, 4'h6, 3'd0, F0);
        add(1, 1, 1, 4'h6, 3'd1, F1);
        add(1, 1, 1, 4'h6, 3'd2, C_IR_OUT | C_PC_LOAD);
        add(1, 1, 1, 4'hE, 3'd0, F0);
        add(1, 1, 1, 4'hE, 3'd1, F1);
        add(1, 1, 1, 4'hE, 3'd2, C_A_OUT | C_OUT_SEL);
        add(1, 1, 1, 4'hE, 3'd0, F0);

        foreach (vt[i]) begin
            drive(vt[i].rn, vt[i].en, vt[i].op);
            if (vt[i].chk) chk_dut($sformatf("vec%0d", i), 0, vt[i].ts, vt[i].ctl, 1'b0);
        end

        // HLT: halts after T2, stays there, only reset leaves
        drive(0, 1, 4'hF);
        drive(1, 1, 4'hF); chk_dut("hlt_rst", 0, 7, 14'h0, 0);
        drive(1, 1, 4'hF); chk_dut("hlt_t0", 0, 0, F0, 0);
        drive(1, 1, 4'hF); chk_dut("hlt_t1", 0, 1, F1, 0);
        drive(1, 1, 4'hF); chk_dut("hlt_t2", 0, 2, 14'h0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 4'hF); chk_dut($sformatf("hlt_hold%0d", i), 0, 5, 14'h0, 1);
        end
        drive(0, 1, 4'hF); chk_dut("hlt_rstcyc", 0, 5, 14'h0, 1);
        drive(1, 1, 4'hF); chk_dut("hlt_back_rst", 0, 7, 14'h0, 0);
        drive(1, 1, 4'hF); chk_dut("hlt_back_t0", 0, 0, F0, 0);

        // Undefined 0x9 on both builds
        drive(0, 1, 4'h9);
        drive(1, 1, 4'h9);
        drive(1, 1, 4'h9);
        drive(1, 1, 4'h9); chk_dut("und_t1_d0", 0, 1, F1, 0); chk_dut("und_t1_d1", 1, 1, F1, 0);
        drive(1, 1, 4'h9); chk_dut("und_c3_d0", 0, 0, F0, 0); chk_dut("und_c3_d1", 1, 2, 14'h0, 0);
        drive(1, 1, 4'h9); chk_dut("und_c4_d0", 0, 1, F1, 0); chk_dut("und_c4_d1", 1, 5, 14'h0, 1);
        drive(1, 1, 4'h9); chk_dut("und_c5_d1", 1, 5, 14'h0, 1);

        // Reset during T3 of STA
        drive(0, 1, 4'h4);
        drive(1, 1, 4'h4);
        drive(1, 1, 4'h4);
        drive(1, 1, 4'h4);
        drive(1, 1, 4'h4); chk_dut("sta_t2", 0, 2, C_IR_OUT | C_MAR, 0);
        drive(0, 1, 4'h4); chk("sta_t3_ts", int'(ts_o[0]), 3);
        drive(1, 1, 4'h4); chk_dut("sta_after_rst", 0, 7, 14'h0, 0);
        chk("sta_no_we", int'(ram_we_o[0]), 0);

        // Random sweep of both builds against the model
        drive(0, 1, 4'h0);
        ms[0] = -1; ms[1] = -1;
        for (int c = 0; c < 2000; c++) begin
            bit rn, en;
            logic [3:0] op;
            rn = ($urandom_range(0, 63) != 0);
            en = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            drive(rn, en, op);
            for (int d = 0; d < 2; d++) begin
                int L, ets;
                logic [13:0] ectl;
                L    = len_t[d][op];
                ets  = (ms[d] < 0) ? 7 : ms[d];
                ectl = (en && ms[d] >= 0 && ms[d] <= 4 && ms[d] < L) ? stp_t[d][op][ms[d]] : 14'h0;
                chk_dut($sformatf("rnd%0d_d%0d", c, d), d, ets, ectl, ms[d] == 5);
                chk_true($sformatf("rnd%0d_d%0d_bus", c, d),
                         $countones({pc_out_o[d], ram_out_o[d], ir_out_o[d], a_out_o[d], alu_out_o[d]}) <= 1,
                         int'(ctl_of(d)));
                chk_true($sformatf("rnd%0d_d%0d_ram", c, d), !(ram_we_o[d] && ram_out_o[d]), int'(ctl_of(d)));
                chk_true($sformatf("rnd%0d_d%0d_pc", c, d), !(pc_inc_o[d] && pc_load_o[d]), int'(ctl_of(d)));
                if (!rn) ms[d] = -1;
                else if (!en) ms[d] = ms[d];
                else if (ms[d] == -1) ms[d] = 0;
                else if (ms[d] == 5) ms[d] = 5;
                else if (ms[d] + 1 < L) ms[d] = ms[d] + 1;
                else if (hlt_t[d][op] && ms[d] == L - 1) ms[d] = 5;
                else ms[d] = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode control unit for the 8-bit CPU; sits directly upstream of the register blocks (A, B, IR, MAR, OUT, PC, RAM).
- Steps fixed T-states and produces the one-cycle load-select pulses that those registers sample on the next posedge.
- Also produces the bus-drive enables, ALU mode, RAM write and PC control.
- Decodes the 4-bit opcode held in the IR's upper nibble.

Parameters:
- OPCODE_W, 4, opcode width taken from IR[7:4]
- HALT_ON_UNDEF, 0, 1 = undefined opcodes behave as HLT; 0 = undefined opcodes behave as NOP

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- enable  in  1  run/stall; 0 freezes the sequencer and forces all control outputs to 0
- opcode  in  OPCODE_W  IR[7:4], stable from the cycle after IR load
- pc_out, pc_inc, pc_load  out  1 each  PC drives bus / increments / loads from bus
- mar_sel  out  1  MAR load select
- ram_out, ram_we  out  1 each  RAM drives bus / RAM write
- ir_sel, ir_out  out  1 each  IR load select / IR operand nibble drives bus
- a_sel, a_out, b_sel, out_sel  out  1 each  register load selects and A bus drive
- alu_out, alu_sub  out  1 each  ALU drives bus / subtract mode
- halted  out  1  high in HALT state
- tstate  out  3  state code: T0..T4 = 0..4, HALT = 5, RST = 7

Behaviour:
- Single state register; all outputs are combinational decode of state, opcode and enable (Moore w.r.t. state).
- Reset: any posedge with rst_n=0 sets state RST regardless of current state, mid-instruction included. RST outputs: all controls 0, halted=0, tstate=7. The next enabled cycle moves to T0.
- enable=0: state holds; every control output is 0; halted and tstate still reflect state.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_sel.
  - T1: ram_out, ir_sel, pc_inc.
  - T1 always goes to T2, except NOP/undefined (HALT_ON_UNDEF=0), which go straight to T0.
- Execute phase; the last listed step of each opcode returns to T0 on the next cycle:
  - 0x1 LDA: T2 ir_out,mar_sel; T3 ram_out,a_sel.
  - 0x2 ADD: T2 ir_out,mar_sel; T3 ram_out,b_sel; T4 alu_out,a_sel.
  - 0x3 SUB: as ADD, plus alu_sub in T4.
  - 0x4 STA: T2 ir_out,mar_sel; T3 a_out,ram_we.
  - 0x5 LDI: T2 ir_out,a_sel.
  - 0x6 JMP: T2 ir_out,pc_load.
  - 0xE OUT: T2 a_out,out_sel.
  - 0xF HLT: T2 no controls; next state HALT.
  - Undefined with HALT_ON_UNDEF=1: treated as HLT.
- HALT: all controls 0, halted=1, tstate=5. Only reset leaves HALT.
- Opcode is sampled only in T2..T4 and in T1 for the NOP shortcut. Changes to opcode in T0 are ignored.
- Invariants, checked every cycle:
  - At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is high.
  - Never both ram_we and ram_out.
  - pc_inc and pc_load are never high together.
- Cycle counts: instruction length is 2 (NOP), 3 (LDI/JMP/OUT), 4 (LDA/STA) or 5 (ADD/SUB) enabled cycles.

Test Plan:
- Reset and fetch: rst_n=0 for 2 cycles then 1, enable=1, opcode=0x5.
  - First cycle tstate=7, all controls 0.
  - Next: tstate=0 with pc_out=mar_sel=1.
  - Then tstate=1 with ram_out=ir_sel=pc_inc=1.
  - Then tstate=2 with ir_out=a_sel=1.
  - Then tstate=0.
- ADD/SUB sequence: opcode=0x2.
  - T2 ir_out+mar_sel; T3 ram_out+b_sel; T4 alu_out+a_sel with alu_sub=0; 5 cycles total.
  - Repeat with 0x3: alu_sub=1 in T4 only.
- Stall: opcode=0x1, drop enable at T3 for 3 cycles.
  - tstate stays 3 and all controls 0 during the stall.
  - On re-enable, ram_out+a_sel fire exactly once, then T0.
- HLT and undefined opcodes:
  - opcode=0xF: after T2, halted=1 and tstate=5 for 10 cycles with every control 0; rst_n=0 then returns to RST then T0.
  - opcode=0x9 with HALT_ON_UNDEF=0: T1 goes directly to T0, 2-cycle instruction.
  - opcode=0x9 with HALT_ON_UNDEF=1: enters HALT.
- Reset mid-operation: assert rst_n=0 during T3 of STA.
  - ram_we never pulses in the following cycle; tstate=7.
- Invariant sweep: random opcodes 0x0..0xF, random enable over 2000 cycles.
  - Bus-driver one-hot-or-zero and the pc_inc/pc_load and ram_we/ram_out exclusions hold every cycle.
